// File: rtl/recip_wave_gen_if.sv
// Control/sample bus between the function-generator controller and the
// reciprocal-curve waveform generator.
interface recip_wave_gen_if #(
  parameter int W = 8
);
  logic         en;
  logic [W-1:0] step;
  logic [1:0]   mode;
  logic [W-1:0] wave;
  logic         sample_valid;
  logic         busy;

  modport master (output en, step, mode, input wave, sample_valid, busy);
  modport slave  (input en, step, mode, output wave, sample_valid, busy);
endinterface

// File: rtl/recip_wave_gen.sv
// Reciprocal-curve waveform generator: each sample is floor(MAX/d) from a
// W-cycle restoring divider, with d derived from a stepping phase counter.
module recip_wave_gen #(
  parameter int W = 8
) (
  input  logic            clk,
  input  logic            rst,
  recip_wave_gen_if.slave bus
);

  localparam int              BW      = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0]    MAX     = '1;
  localparam logic [W-1:0]    MAX_M1  = MAX - 1'b1;
  localparam logic [BW-1:0]   BIT_TOP = BW'(W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         dir_up_q, dir_up_d;
  logic [1:0]   mode_q, mode_d;
  logic [W-1:0] step_q, step_d;
  logic [W-1:0] div_q, div_d;
  logic [W-1:0] rem_q, rem_d;
  logic [W-1:0] quot_q, quot_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [W-1:0] wave_q, wave_d;
  logic         sv_q, sv_d;
  logic         busy;
  logic [W:0]   trial;
  logic [W:0]   sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.en) state_d = LOAD;
      LOAD:    state_d = DIV;
      DIV:     if (bit_q == '0) state_d = DONE;
      DONE:    state_d = bus.en ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  always_comb begin
    cnt_d    = cnt_q;
    dir_up_d = dir_up_q;
    mode_d   = mode_q;
    step_d   = step_q;
    div_d    = div_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    bit_d    = bit_q;
    wave_d   = wave_q;
    sv_d     = 1'b0;
    // Dividend is MAX, so every bit shifted into the remainder is a 1.
    trial    = {rem_q, 1'b1};
    sum      = {1'b0, cnt_q} + {1'b0, step_q};
    case (state_q)
      LOAD: begin
        mode_d = bus.mode;
        step_d = bus.step;
        if (bus.mode != 2'd2) dir_up_d = 1'b1;
        div_d  = (bus.mode == 2'd1) ? cnt_q + 1'b1 : MAX - cnt_q;
        rem_d  = '0;
        quot_d = '0;
        bit_d  = BIT_TOP;
      end
      DIV: begin
        if (trial >= {1'b0, div_q}) begin
          rem_d  = trial[W-1:0] - div_q;
          quot_d = {quot_q[W-2:0], 1'b1};
        end else begin
          rem_d  = trial[W-1:0];
          quot_d = {quot_q[W-2:0], 1'b0};
        end
        bit_d = bit_q - 1'b1;
      end
      DONE: begin
        wave_d = quot_q;
        sv_d   = 1'b1;
        if (mode_q == 2'd2) begin
          // Bounce clamps at the ends rather than reflecting the overshoot.
          if (dir_up_q) begin
            if (sum >= {1'b0, MAX_M1}) begin
              cnt_d    = MAX_M1;
              dir_up_d = 1'b0;
            end else begin
              cnt_d = sum[W-1:0];
            end
          end else if (cnt_q <= step_q) begin
            cnt_d    = '0;
            dir_up_d = 1'b1;
          end else begin
            cnt_d = cnt_q - step_q;
          end
        end else if (sum >= {1'b0, MAX}) begin
          cnt_d = sum[W-1:0] - MAX;
        end else begin
          cnt_d = sum[W-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      dir_up_q <= 1'b1;
      mode_q   <= '0;
      step_q   <= '0;
      div_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      bit_q    <= '0;
      wave_q   <= '0;
      sv_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      dir_up_q <= dir_up_d;
      mode_q   <= mode_d;
      step_q   <= step_d;
      div_q    <= div_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      bit_q    <= bit_d;
      wave_q   <= wave_d;
      sv_q     <= sv_d;
    end
  end

  assign bus.wave         = wave_q;
  assign bus.sample_valid = sv_q;
  assign bus.busy         = busy;

endmodule

// File: tb/tb_recip_wave_gen.sv
// Directed and randomized checks of recip_wave_gen against an arithmetic
// model of the phase counter and reciprocal curve.
module tb_recip_wave_gen;
  localparam int W   = 8;
  localparam int MAX = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst;

  recip_wave_gen_if #(.W(W)) bus ();

  recip_wave_gen #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int m_cnt;
  bit m_up;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int curve(input int m, input int c);
    int d;
    d = (m == 1) ? c + 1 : MAX - c;
    return MAX / d;
  endfunction

  task automatic advance(input int m, input int s);
    if (m == 2) begin
      if (m_up) begin
        if (m_cnt + s >= MAX - 1) begin
          m_cnt = MAX - 1;
          m_up  = 1'b0;
        end else begin
          m_cnt = m_cnt + s;
        end
      end else if (m_cnt <= s) begin
        m_cnt = 0;
        m_up  = 1'b1;
      end else begin
        m_cnt = m_cnt - s;
      end
    end else begin
      m_cnt = (m_cnt + s) % MAX;
    end
  endtask

  // Called on the negedge where the previous pulse is seen (or from IDLE);
  // inputs are garbled mid-division to prove the captured copies are used.
  task automatic run_sample(input int m, input int s, input int period,
                            input bit drop_en, input string tag);
    int cyc;
    int expv;
    bus.mode = 2'(m);
    bus.step = W'(s);
    if (m != 2) m_up = 1'b1;
    expv = curve(m, m_cnt);
    cyc  = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 3) begin
        bus.mode = 2'($urandom_range(3, 0));
        bus.step = W'($urandom_range(MAX, 0));
        if (drop_en) bus.en = 1'b0;
      end
    end while (!bus.sample_valid && cyc < 40);
    chk({tag, "_period"}, cyc, period);
    chk({tag, "_wave"}, bus.wave, expv);
    chk({tag, "_busy"}, bus.busy, bus.en);
    advance(m, s);
  endtask

  task automatic reset_mid_div();
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_wave", bus.wave, 0);
    chk("arst_valid", bus.sample_valid, 0);
    chk("arst_busy", bus.busy, 0);
    @(negedge clk);
    rst   = 1'b0;
    m_cnt = 0;
    m_up  = 1'b1;
  endtask

  initial begin
    logic [W-1:0] held;
    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.mode = 2'd0;
    bus.step = W'(1);
    m_cnt    = 0;
    m_up     = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_wave", bus.wave, 0);
    chk("rst_valid", bus.sample_valid, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);

    bus.en = 1'b1;
    run_sample(0, 1, W + 3, 1'b0, "m0s1_first");
    for (int i = 0; i < MAX; i++) run_sample(0, 1, W + 2, 1'b0, "m0s1_sweep");

    reset_mid_div();
    run_sample(1, 1, W + 3, 1'b0, "m1s1");
    for (int i = 0; i < 4; i++) run_sample(1, 1, W + 2, 1'b0, "m1s1");

    reset_mid_div();
    run_sample(2, 100, W + 3, 1'b0, "m2s100");
    for (int i = 0; i < 7; i++) run_sample(2, 100, W + 2, 1'b0, "m2s100");

    reset_mid_div();
    run_sample(0, 100, W + 3, 1'b0, "m0s100");
    for (int i = 0; i < 3; i++) run_sample(0, 100, W + 2, 1'b0, "m0s100");

    run_sample(0, 100, W + 2, 1'b1, "en_drop");
    held = bus.wave;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_valid", bus.sample_valid, 0);
      chk("idle_busy2", bus.busy, 0);
      chk("idle_wave", bus.wave, held);
    end

    bus.en = 1'b1;
    run_sample(0, 0, W + 3, 1'b0, "step0");
    for (int i = 0; i < 3; i++) run_sample(0, 0, W + 2, 1'b0, "step0");

    for (int i = 0; i < 40; i++)
      run_sample(int'($urandom_range(3, 0)), int'($urandom_range(MAX, 0)),
                 W + 2, 1'b0, "rand");

    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end
endmodule

// File: doc/recip_wave_gen.md
# recip_wave_gen

Parametrised reciprocal-curve waveform generator for the function-generator datapath. A phase index drives a W-cycle restoring divider that produces one sample per division. The block supports selectable curve modes and a programmable phase step. Each new sample is flagged with a one-cycle strobe to the DAC/output stage, which replaces an unbounded combinational divide.

## Interface
- W, default 8: sample/phase width; MAX = 2^W − 1 (255 at W=8).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  run enable; sampled in IDLE and DONE.
- step  in  W  phase increment per sample; 0 holds phase.
- mode  in  2  curve: 0 rising 1/x, 1 falling 1/x, 2 bounce (rise then fall), 3 = same as 0.
- wave  out  W  current sample, registered.
- sample_valid  out  1  one-cycle pulse when wave updates.
- busy  out  1  high in LOAD, DIV, DONE.

## Operation
- Reset value of every output is 0: wave, sample_valid, busy. Internal state on reset: state=IDLE, phase cnt=0, dir=up, quotient/remainder/bit counter all 0.
- FSM states: IDLE, LOAD, DIV, DONE.
- IDLE: goes to LOAD when en=1, otherwise stays. wave holds its value.
- LOAD: captures mode and step into shadow registers. Later changes to either take effect at the next LOAD.
  - Divisor d = MAX − cnt for modes 0, 2, 3.
  - Divisor d = cnt + 1 for mode 1.
  - d is never 0 because cnt ∈ [0, MAX−1].
  - Dividend is MAX. Remainder is cleared and the bit counter is set to W−1. Next state is DIV.
- DIV: performs one restoring-division step per cycle, MSB first, for exactly W cycles.
  - Each step: remainder = {rem, dividend bit}. If remainder ≥ d, subtract d and set the quotient bit.
  - The remainder is W+1 bits wide so it never overflows.
  - The state goes to DONE after the step with bit counter = 0.
- DONE: sets wave ← q, where q = floor(MAX/d), so 1 ≤ q ≤ MAX. Pulses sample_valid for this one cycle.
  - Advances the phase; the step used is the value captured in LOAD.
  - Then goes to LOAD if en=1, else to IDLE.
- Phase advance, modes 0, 1, 3: cnt ← (cnt + step) mod MAX. Computed W+1 bits wide: if cnt+step ≥ MAX, subtract MAX.
- Phase advance, mode 2 (bounce, clamped rather than reflected):
  - dir=up: if cnt+step ≥ MAX−1, set cnt ← MAX−1 and dir ← down; else cnt += step.
  - dir=down: if cnt ≤ step, set cnt ← 0 and dir ← up; else cnt −= step.
  - dir is forced to up whenever a LOAD captures a mode other than 2.
- step=0: cnt is unchanged and the same value is re-emitted every sample period.
- en deasserted mid-sample: the current division completes and sample_valid fires, then the FSM returns to IDLE. No sample is ever aborted except by rst.
- rst mid-operation: immediate return to reset values. The pending sample is discarded and no sample_valid is produced.

## Timing
- Number edges so that edge 1 is the one that samples en=1 in IDLE.
- State sequence: edge 1 IDLE→LOAD, edge 2 LOAD→DIV, edges 3..W+2 are the division steps, edge W+2 enters DONE.
- wave and sample_valid update on edge W+3, which is 11 at W=8.
- With en held high: period is W+2 cycles (10 at W=8), with one sample_valid pulse per period and never two consecutive.
- busy rises on edge 1. It falls on the edge leaving DONE toward IDLE.
- Output latency from the cnt value to its wave is W+2 cycles after LOAD.

## Test plan
- Reset: assert rst asynchronously mid-DIV → wave=0, sample_valid=0, busy=0 immediately. After release with en=1, the first sample is 1 (cnt=0, mode 0).
- Mode 0, step=1, W=8: samples are 1 (×128, cnt 0..127), then 2 at cnt=128, …, 255 at cnt=254. Then wraps to 1. Pulses are 10 cycles apart.
- Mode 1, step=1: samples are 255, 127, 85, 63, 51 for cnt=0..4.
- Mode 2, step=100: cnt sequence 0, 100, 200, 254, 154, 54, 0, 100 → wave 1, 1, 4, 255, 2, 1, 1, 1.
- Mode 0, step=100: cnt 0, 100, 200, 45 (wrap) → wave 1, 1, 4, 1. Changing step during DIV does not alter the in-flight cnt advance.
- Drop en during the 3rd DIV cycle: the sample still completes on schedule with one sample_valid. Then IDLE with busy=0 and wave held. step=0 with en=1 → a constant wave every 10 cycles.
